ctech_lib_clk_div: RTL

Programmable, glitch-free integer clock divider that generates the divided clock consumed by `ctech_lib_clk_inv` and other ctech clock cells. All state is synchronous to the source clock. Divide-ratio changes and start/stop take effect only on period boundaries, so the divided clock never produces a runt pulse. Status outputs let the clock-control sequencer know when a ratio change has landed and whether the output is toggling.

---
 rtl/ctech_lib_clk_div.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ctech_lib_clk_div.sv
// Glitch-free programmable integer clock divider. Ratio changes and start/stop
// only land on period boundaries; clkout is always a flop output.
module ctech_lib_clk_div #(
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_busy,
  output logic             div_ack,
  output logic             clkout,
  output logic             running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] N_RST = DIV_RST[DIV_W-1:0];
  localparam logic [DIV_W-1:0] N_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO  = DIV_W'(0);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_cur_q, n_cur_d;
  logic [DIV_W-1:0] n_pend_q, n_pend_d;
  logic             clkout_q, clkout_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             running_q, running_d;
  logic             accept_s;
  logic             boundary_s;
  logic [DIV_W-1:0] val_clamp_s;

  function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] v);
    return (v < N_MIN) ? N_MIN : v;
  endfunction

  // High phase is the first ceil(N/2) counts; extra bit avoids overflow at N=2^W-1.
  function automatic logic high_phase(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] n);
    logic [DIV_W:0] half;
    half = ({1'b0, n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return ({1'b0, c} < half);
  endfunction

  // Next-state: phase counter, run/stop sequencing and boundary-aligned ratio swap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_cur_d     = n_cur_q;
    n_pend_d    = n_pend_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    accept_s    = div_req & ~busy_q;
    val_clamp_s = clamp_ratio(div_val);
    boundary_s  = (cnt_q == (n_cur_q - ONE));

    if (accept_s) begin
      n_pend_d = val_clamp_s;
      busy_d   = 1'b1;
    end else begin
      n_pend_d = n_pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d   = ZERO;
        state_d = en ? ST_RUN : ST_IDLE;
        // No clock is running, so a new ratio can be applied on the accepting edge.
        if (accept_s) begin
          n_cur_d = val_clamp_s;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end else if (busy_q) begin
          n_cur_d = n_pend_q;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end else begin
          n_cur_d = n_cur_q;
        end
      end
      ST_RUN, ST_STOP: begin
        if (boundary_s) begin
          cnt_d   = ZERO;
          state_d = en ? ST_RUN : ST_IDLE;
          if (busy_q) begin
            n_cur_d = n_pend_q;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
          end else begin
            n_cur_d = n_cur_q;
          end
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = en ? ST_RUN : ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO;
      end
    endcase

    running_d = (state_d != ST_IDLE);
    clkout_d  = running_d & high_phase(cnt_d, n_cur_d);
  end

  // All state and outputs are flops on the source clock.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      cnt_q     <= ZERO;
      n_cur_q   <= N_RST;
      n_pend_q  <= N_RST;
      clkout_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_cur_q   <= n_cur_d;
      n_pend_q  <= n_pend_d;
      clkout_q  <= clkout_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      running_q <= running_d;
    end
  end

  assign clkout   = clkout_q;
  assign div_busy = busy_q;
  assign div_ack  = ack_q;
  assign running  = running_q;

endmodule
